// File: rtl/gb_cmd_master.sv
// Single-outstanding command master for the ghostbus: accepts one command,
// strobes the bus for one cycle, waits RD_LAT cycles for reads, and returns one response.
module gb_cmd_master #(
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata,
    output logic [15:0]   txn_count
);

    typedef enum logic [1:0] {IDLE, STRB, RWAIT, RESP} state_t;

    // RWAIT spans RD_LAT cycles; the counter ends at zero on the sampling cycle.
    localparam logic [3:0] WAIT_INIT = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

    state_t     state, state_nxt;
    logic       armed;
    logic       we_q;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       sample;

    // armed keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready = armed && (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        sample    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = STRB;
            end
            STRB: begin
                if (we_q) begin
                    state_nxt = RESP;
                end else if (RD_LAT == 0) begin
                    sample    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    state_nxt = RWAIT;
                end
            end
            RWAIT: begin
                if (wait_cnt == 4'd0) begin
                    sample    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            we_q      <= 1'b0;
            wait_cnt  <= 4'd0;
            gb_addr   <= '0;
            gb_wdata  <= '0;
            gb_wen    <= 1'b0;
            gb_rstb   <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            txn_count <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values.
            state   <= state_nxt;
            armed   <= 1'b1;
            // Strobes are registered off the accept edge, so they are high exactly in STRB.
            gb_wen  <= accept && cmd_we;
            gb_rstb <= accept && !cmd_we;

            if (accept) begin
                we_q     <= cmd_we;
                gb_addr  <= cmd_addr;
                gb_wdata <= cmd_wdata;
            end

            if (state == STRB) begin
                wait_cnt <= WAIT_INIT;
                if (we_q) begin
                    rsp_we    <= 1'b1;
                    rsp_rdata <= '0;
                end
            end else if (state == RWAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (sample) begin
                rsp_we    <= 1'b0;
                rsp_rdata <= gb_rdata;
            end

            if (rsp_valid && rsp_ready) txn_count <= txn_count + 16'd1;
        end
    end

endmodule

// File: doc/gb_cmd_master.md
GB_CMD_MASTER -- requirements
Module: gb_cmd_master

Interface
REQ-001 Parameter AW, default 24, ghostbus address width.
REQ-002 Parameter DW, default 32, ghostbus data width.
REQ-003 Parameter RD_LAT, default 2, range 0..15, cycles from gb_rstb assertion to the gb_rdata sample edge.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-009 cmd_we  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  AW  target address.
REQ-011 cmd_wdata  in  DW  write data; ignored for reads.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-014 rsp_we  out  1  echo of cmd_we for this response.
REQ-015 rsp_rdata  out  DW  read data; 0 for write responses.
REQ-016 gb_addr  out  AW  ghostbus address, registered.
REQ-017 gb_wdata  out  DW  ghostbus write data, registered.
REQ-018 gb_wen  out  1  ghostbus write strobe, one-cycle pulse.
REQ-019 gb_rstb  out  1  ghostbus read strobe, one-cycle pulse.
REQ-020 gb_rdata  in  DW  ghostbus read data.
REQ-021 txn_count  out  16  count of completed responses.

Function
REQ-022 FSM states SHALL be IDLE, STRB, RWAIT and RESP.
REQ-023 cmd_ready SHALL equal (state==IDLE); it SHALL NOT depend combinationally on cmd_valid.
REQ-024 IDLE->STRB on cmd_valid&&cmd_ready (cycle 0); cmd_we, cmd_addr and cmd_wdata SHALL be latched at that edge.
REQ-025 In STRB (cycle 1), gb_addr and gb_wdata SHALL present the latched values, and exactly one of gb_wen or gb_rstb SHALL be high, selected by the latched we.
REQ-026 gb_wen and gb_rstb SHALL be high only in STRB and never high together.
REQ-027 gb_addr and gb_wdata SHALL hold their last values outside STRB.
REQ-028 STRB->RESP for writes, and for reads when RD_LAT==0 (gb_rdata sampled at the end of STRB).
REQ-029 STRB->RWAIT for reads when RD_LAT>0; RWAIT SHALL last exactly RD_LAT cycles.
REQ-030 gb_rdata SHALL be sampled on the edge that ends the last RWAIT cycle (cycle 1+RD_LAT), then RWAIT->RESP.
REQ-031 Response latency SHALL be: rsp_valid first high in cycle 2 for writes and cycle 2+RD_LAT for reads.
REQ-032 In RESP, rsp_valid SHALL be 1; rsp_we and rsp_rdata SHALL be stable until the handshake.
REQ-033 RESP->IDLE on rsp_ready; rsp_valid SHALL drop the next cycle.
REQ-034 Sustained throughput SHALL be one transaction per 3 cycles (write) or 3+RD_LAT cycles (read) when rsp_ready is held high.
REQ-035 rsp_ready stalls SHALL hold RESP indefinitely with no further bus strobes.
REQ-036 cmd_valid asserted outside IDLE SHALL be ignored; no command SHALL be queued.
REQ-037 txn_count SHALL increment by 1 on each rsp handshake and wrap 0xFFFF->0x0000.

Reset
REQ-038 While rst_n is low: state=IDLE; cmd_ready=0; rsp_valid=0; gb_wen=0; gb_rstb=0; gb_addr=0; gb_wdata=0; rsp_we=0; rsp_rdata=0; txn_count=0.
REQ-039 cmd_ready SHALL go high on the first clk edge after rst_n deasserts.
REQ-040 Reset mid-transaction SHALL abort it immediately: no strobe completes and no response is produced afterward.

Verification
REQ-041 Write addr 0x000123, data 0xDEADBEEF, rsp_ready=1 -> gb_wen high only in cycle 1 with gb_addr=0x000123 and gb_wdata=0xDEADBEEF; rsp_valid in cycle 2 with rsp_we=1 and rsp_rdata=0; txn_count=1.
REQ-042 Read, RD_LAT=2, gb_rdata=0x00000042 in cycle 3 only -> gb_rstb pulses in cycle 1; rsp_valid in cycle 4 with rsp_rdata=0x00000042 and rsp_we=0.
REQ-043 Read, RD_LAT=0, combinational gb_rdata=0xA5A5A5A5 -> rsp_valid in cycle 2 with rsp_rdata=0xA5A5A5A5.
REQ-044 rsp_ready held low 10 cycles after a read, with cmd_valid held high throughout -> rsp_valid held with stable data; cmd_ready=0; no strobes; next command accepted 1 cycle after the handshake.
REQ-045 Preload 0xFFFF transactions, or force txn_count=0xFFFF, then complete one write -> txn_count=0x0000.
REQ-046 rst_n low during RWAIT -> all outputs 0 asynchronously; no rsp_valid after release; first new command completes normally.
